// File: rtl/mic_ram_pkg.sv
// Shared definitions for the mic-array ping-pong frame writer: FSM states,
// header field positions and the saturating drop counter helper.
package mic_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HDR  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam int SEQ_MSB  = 31;
    localparam int SEQ_LSB  = 16;
    localparam int DROP_MSB = 15;
    localparam int DROP_LSB = 0;

    localparam logic [3:0] BE_ALL = 4'hF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mic_frame_ram_writer_if.sv
// Sample stream plus RAM s2 write port of the frame writer.
// master = the writer itself, slave = sample source / RAM side.
interface mic_frame_ram_writer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] ram_block_s2_address;
    logic              ram_block_s2_chipselect;
    logic              ram_block_s2_clken;
    logic              ram_block_s2_write;
    logic [DATA_W-1:0] ram_block_s2_writedata;
    logic [3:0]        ram_block_s2_byteenable;

    modport master (
        input  s_valid, s_data,
        output s_ready,
        output ram_block_s2_address, ram_block_s2_chipselect, ram_block_s2_clken,
        output ram_block_s2_write, ram_block_s2_writedata, ram_block_s2_byteenable
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready,
        input  ram_block_s2_address, ram_block_s2_chipselect, ram_block_s2_clken,
        input  ram_block_s2_write, ram_block_s2_writedata, ram_block_s2_byteenable
    );
endinterface

// File: rtl/mic_frame_ram_writer.sv
// Ping-pong frame writer: fills one RAM half with samples, closes it with a
// {seq, drop_cnt} header word and flags it pending for the Nios to drain.
module mic_frame_ram_writer
    import mic_ram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   enable,
    input  logic                   irq_ack,
    mic_frame_ram_writer_if.master bus,
    output logic                   ext_irq_adapter_new_signal,
    output logic                   ready_half,
    output logic [15:0]            frame_seq
);

    localparam int              HALF_W    = ADDR_W - 1;
    localparam logic [HALF_W-1:0] OFF_FIRST = HALF_W'(1);
    localparam logic [HALF_W-1:0] OFF_LAST  = {HALF_W{1'b1}};

    state_t              r_state;
    state_t              w_nxt_state;
    logic                r_fill_half;
    logic                r_rd_ptr;
    logic                r_commit;
    logic                r_commit_half;
    logic                r_s_ready;
    logic                r_wr;
    logic                r_irq;
    logic [1:0]          r_pending;
    logic [1:0]          w_pending_nxt;
    logic [15:0]         r_seq;
    logic [15:0]         r_drop_cnt;
    logic [HALF_W-1:0]   r_off;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic [DATA_W-1:0]   w_hdr;
    logic [3:0]          r_be;
    logic                w_accept;
    logic                w_wr_nxt;
    logic                w_s_ready_nxt;
    logic                w_ack_hit;
    logic                w_drop_acc;

    assign w_accept   = bus.s_valid & r_s_ready;
    assign w_ack_hit  = irq_ack & r_pending[r_rd_ptr];
    assign w_drop_acc = (r_state == ST_DROP) & w_accept;

    // Completed half is committed one cycle after its header write; an ack of
    // the other half in that same cycle still lands.
    assign w_pending_nxt[0] = (r_pending[0] | (r_commit & (r_commit_half == 1'b0)))
                              & ~(w_ack_hit & (r_rd_ptr == 1'b0));
    assign w_pending_nxt[1] = (r_pending[1] | (r_commit & (r_commit_half == 1'b1)))
                              & ~(w_ack_hit & (r_rd_ptr == 1'b1));

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic; HDR looks at the half it is about to switch to
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: w_nxt_state = !enable ? ST_IDLE :
                                   (r_pending[r_fill_half] ? ST_DROP : ST_FILL);
            ST_FILL: w_nxt_state = (w_accept && (r_off == OFF_LAST)) ? ST_HDR : ST_FILL;
            ST_HDR:  w_nxt_state = !enable ? ST_IDLE :
                                   (r_pending[~r_fill_half] ? ST_DROP : ST_FILL);
            ST_DROP: w_nxt_state = !enable ? ST_IDLE :
                                   (r_pending[r_fill_half] ? ST_DROP : ST_FILL);
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // Output decode: next write beat and next s_ready
    always_comb begin
        w_hdr                     = '0;
        w_hdr[SEQ_MSB:SEQ_LSB]    = r_seq;
        w_hdr[DROP_MSB:DROP_LSB]  = r_drop_cnt;
        w_wr_nxt                  = 1'b0;
        w_addr_nxt                = '0;
        w_wdata_nxt               = '0;
        case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = {r_fill_half, r_off};
                    w_wdata_nxt = bus.s_data;
                end else begin
                    w_wr_nxt    = 1'b0;
                end
            end
            ST_HDR: begin
                w_wr_nxt    = 1'b1;
                w_addr_nxt  = {r_fill_half, {HALF_W{1'b0}}};
                w_wdata_nxt = w_hdr;
            end
            default: w_wr_nxt = 1'b0;
        endcase
        w_s_ready_nxt = (w_nxt_state == ST_FILL) || (w_nxt_state == ST_DROP);
    end

    // Datapath, bookkeeping and registered outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_fill_half   <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_pending     <= 2'b00;
            r_commit      <= 1'b0;
            r_commit_half <= 1'b0;
            r_seq         <= 16'd0;
            r_drop_cnt    <= 16'd0;
            r_off         <= OFF_FIRST;
            r_s_ready     <= 1'b0;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= 4'h0;
            r_irq         <= 1'b0;
        end else begin
            r_s_ready     <= w_s_ready_nxt;
            r_wr          <= w_wr_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_be          <= w_wr_nxt ? BE_ALL : 4'h0;
            r_commit      <= (r_state == ST_HDR);
            r_commit_half <= r_fill_half;
            r_pending     <= w_pending_nxt;
            r_irq         <= |w_pending_nxt;
            r_rd_ptr      <= w_ack_hit ? ~r_rd_ptr : r_rd_ptr;
            r_seq         <= r_commit ? r_seq + 16'd1 : r_seq;
            if (r_state == ST_HDR) begin
                r_fill_half <= ~r_fill_half;
                r_off       <= OFF_FIRST;
            end else if ((r_state == ST_FILL) && w_accept) begin
                r_off       <= r_off + HALF_W'(1);
            end else begin
                r_off       <= r_off;
            end
            // A drop landing on the commit cycle already belongs to the next frame
            if (r_commit) begin
                r_drop_cnt <= w_drop_acc ? 16'd1 : 16'd0;
            end else if (w_drop_acc) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign bus.s_ready                 = r_s_ready;
    assign bus.ram_block_s2_write      = r_wr;
    assign bus.ram_block_s2_chipselect = r_wr;
    assign bus.ram_block_s2_clken      = r_wr;
    assign bus.ram_block_s2_address    = r_addr;
    assign bus.ram_block_s2_writedata  = r_wdata;
    assign bus.ram_block_s2_byteenable = r_be;
    assign ext_irq_adapter_new_signal  = r_irq;
    assign ready_half                  = r_rd_ptr;
    assign frame_seq                   = r_seq;

endmodule

// File: tb/tb_mic_frame_ram_writer.sv
// Self-checking bench for mic_frame_ram_writer (ADDR_W=4, 8 words per half)
// against a frame-level model of samples, drops, headers and pending halves.
module tb_mic_frame_ram_writer;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int N      = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        irq_ack;
    logic        irq;
    logic        ready_half;
    logic [15:0] frame_seq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    wr_t         exp_q[$];
    logic [1:0]  m_pend;
    logic        m_rd;
    logic        m_fill;
    logic [15:0] m_seq;
    logic [15:0] m_drop;
    int          m_off;
    logic [31:0] last_hdr;

    mic_frame_ram_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mic_frame_ram_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_clk                    (clk),
        .reset_reset                (rst),
        .enable                     (enable),
        .irq_ack                    (irq_ack),
        .bus                        (bus.master),
        .ext_irq_adapter_new_signal (irq),
        .ready_half                 (ready_half),
        .frame_seq                  (frame_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pend = 2'b00; m_rd = 1'b0; m_fill = 1'b0;
        m_seq = 16'd0; m_drop = 16'd0; m_off = 1;
    endtask

    // Frame-level model plus write scoreboard, evaluated away from the active edge
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (bus.ram_block_s2_write || bus.ram_block_s2_chipselect || bus.ram_block_s2_clken) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {28'd0, bus.ram_block_s2_address}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {28'd0, bus.ram_block_s2_address}, {28'd0, e.addr});
                chk("wr_data", bus.ram_block_s2_writedata, e.data);
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_cs_clken", {30'd0, bus.ram_block_s2_chipselect, bus.ram_block_s2_clken},
                    32'd3);
                chk("wr_be", {28'd0, bus.ram_block_s2_byteenable}, 32'hF);
                if (e.addr[ADDR_W-2:0] == '0) last_hdr = bus.ram_block_s2_writedata;
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            if (bus.s_valid && bus.s_ready) begin
                if (m_pend[m_fill]) begin
                    m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
                end else begin
                    exp_q.push_back('{addr: ADDR_W'(m_fill * N + m_off), data: bus.s_data,
                                      cyc: cyc + 1});
                    m_off++;
                    if (m_off == N) begin
                        exp_q.push_back('{addr: ADDR_W'(m_fill * N), data: {m_seq, m_drop},
                                          cyc: cyc + 2});
                        m_pend[m_fill] = 1'b1;
                        m_seq  = m_seq + 16'd1;
                        m_drop = 16'd0;
                        m_fill = ~m_fill;
                        m_off  = 1;
                    end
                end
            end
            if (irq_ack && m_pend[m_rd]) begin
                m_pend[m_rd] = 1'b0;
                m_rd = ~m_rd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        bus.s_valid = 1'b0;
        repeat (k) tick();
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    // Offer samples until n are accepted or the cycle budget runs out
    task automatic send(input int n, input bit rnd, input logic [31:0] base);
        int got = 0;
        int guard = 0;
        while (got < n && guard < n + 50) begin
            bus.s_valid = 1'b1;
            bus.s_data  = rnd ? $urandom : base + got;
            @(negedge clk);
            if (bus.s_ready) got++;
            tick();
            guard++;
        end
        bus.s_valid = 1'b0;
        if (got < n) chk("send_timeout", got, n);
    endtask

    initial begin
        model_reset();
        last_hdr    = 32'hDEAD_BEEF;
        rst         = 1'b1;
        enable      = 1'b0;
        irq_ack     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_outputs", {bus.s_ready, bus.ram_block_s2_write, bus.ram_block_s2_chipselect,
                            bus.ram_block_s2_clken, irq, ready_half, 26'd0}, 32'd0);
        chk("rst_addr_be", {24'd0, bus.ram_block_s2_address, bus.ram_block_s2_byteenable}, 32'd0);
        chk("rst_wdata", bus.ram_block_s2_writedata, 32'd0);
        chk("rst_seq", {16'd0, frame_seq}, 32'd0);
        tick();
        rst = 1'b0;

        // 1: first frame, exact IRQ latency
        enable = 1'b1;
        tick();
        send(7, 1'b0, 32'h101);
        @(negedge clk);
        @(negedge clk);
        chk("t1_irq_c2", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("t1_irq_c3", {31'd0, irq}, 32'd1);
        chk("t1_ready_half", {31'd0, ready_half}, 32'd0);
        chk("t1_seq", {16'd0, frame_seq}, 32'd1);
        chk("t1_hdr", last_hdr, 32'h0000_0000);
        tick();

        // 2: second half, drops while both pending, header carries drop count
        send(7, 1'b1, 32'd0);
        idle(4);
        chk("t2_hdr1", last_hdr, 32'h0001_0000);
        chk("t2_seq", {16'd0, frame_seq}, 32'd2);
        send(3, 1'b1, 32'd0);
        idle(2);
        ack();
        idle(3);
        send(7, 1'b1, 32'd0);
        idle(4);
        chk("t2_hdr2", last_hdr, 32'h0002_0003);
        chk("t2_irq", {31'd0, irq}, {31'd0, |m_pend});
        chk("t2_ready_half", {31'd0, ready_half}, {31'd0, m_rd});

        // 3: ack with nothing pending, then ack on the pending-set cycle
        ack(); idle(2);
        ack(); idle(3);
        chk("t3_irq_clear", {31'd0, irq}, 32'd0);
        ack(); idle(2);
        chk("t3_ack_ignored", {31'd0, ready_half}, 32'd1);
        chk("t3_irq_still0", {31'd0, irq}, 32'd0);
        send(7, 1'b1, 32'd0);
        idle(4);
        send(7, 1'b1, 32'd0);
        tick();
        ack();
        @(negedge clk);
        chk("t3_coinc_irq", {31'd0, irq}, 32'd1);
        chk("t3_coinc_rd", {31'd0, ready_half}, 32'd0);
        chk("t3_model_pend", {30'd0, m_pend}, 32'd1);
        tick();
        idle(3);

        // 4: enable dropped mid-frame, frame still completes, then IDLE
        send(3, 1'b1, 32'd0);
        enable = 1'b0;
        send(4, 1'b1, 32'd0);
        idle(4);
        bus.s_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("t4_idle_ready", {31'd0, bus.s_ready}, 32'd0);
        tick();
        idle(1);
        ack(); idle(2);
        enable = 1'b1;
        tick();
        send(7, 1'b1, 32'd0);
        idle(4);
        chk("t4_seq", {16'd0, frame_seq}, {16'd0, m_seq});

        // 5: saturating drop counter
        send(70000, 1'b1, 32'd0);
        idle(2);
        ack(); idle(3);
        send(7, 1'b1, 32'd0);
        idle(4);
        chk("t5_drop_sat", {16'd0, last_hdr[15:0]}, 32'h0000_FFFF);
        ack(); idle(3);
        send(7, 1'b1, 32'd0);
        idle(4);
        chk("t5_drop_clear", {16'd0, last_hdr[15:0]}, 32'd0);

        // 6: reset in the middle of a frame
        ack(); idle(3);
        send(3, 1'b1, 32'd0);
        idle(2);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_rst_ctrl", {bus.s_ready, bus.ram_block_s2_write, irq, ready_half, 28'd0}, 32'd0);
        chk("t6_rst_seq", {16'd0, frame_seq}, 32'd0);
        chk("t6_rst_addr", {28'd0, bus.ram_block_s2_address}, 32'd0);
        tick();
        rst = 1'b0;
        last_hdr = 32'hDEAD_BEEF;
        tick();
        send(7, 1'b1, 32'd0);
        idle(4);
        chk("t6_restart_hdr", last_hdr, 32'h0000_0000);
        chk("t6_restart_seq", {16'd0, frame_seq}, 32'd1);
        chk("t6_restart_irq", {31'd0, irq}, 32'd1);

        idle(5);
        chk("drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
